spike_rate_decoder: RTL and testbench
=====================================

SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

Interface
REQ-001 Parameter WINDOW_LOG2, default 8, meaning the decode window is 2^WINDOW_LOG2 clock cycles (legal range 2..16).
REQ-002 Parameter OUT_W, default 8, meaning the width of the decoded rate and the saturation width of the spike counter.
REQ-003 Port clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-004 Port rst_n, input, 1 bit, reset, asynchronous and active-low.
REQ-005 Port en, input, 1 bit, decoder enable; low holds the block idle.
REQ-006 Port spike_in, input, 1 bit, spike train from a LIF neuron; a spike may be high for one or more cycles.
REQ-007 Port rate_ready, input, 1 bit, consumer accepts rate when it is high together with rate_valid.
REQ-008 Port rate, output, OUT_W bits, spike count of the most recently completed window.
REQ-009 Port rate_valid, output, 1 bit, rate holds an unconsumed result.
REQ-010 Port overrun, output, 1 bit, sticky flag: an unconsumed result was overwritten.
REQ-011 Port isi, output, 8 bits, last inter-spike interval in cycles (see REQ-026).

Function
REQ-012 A spike event SHALL be spike_in high in the current cycle and low in the previous registered sample; a held-high spike counts once.
REQ-013 States SHALL be IDLE and COUNT; IDLE->COUNT on the first cycle en is sampled high; COUNT->IDLE on the first cycle en is sampled low.
REQ-014 In IDLE, window counter, spike counter, rate_valid and overrun SHALL be held at 0; rate SHALL keep its last value.
REQ-015 In COUNT, the window counter SHALL increment every cycle from 0 and wrap from 2^WINDOW_LOG2-1 to 0; windows SHALL run back-to-back with no gap.
REQ-016 The spike counter SHALL increment on each spike event and saturate at 2^OUT_W-1.
REQ-017 On the last window cycle (counter = 2^WINDOW_LOG2-1), the closing count, including any event in that same cycle, SHALL be loaded into rate, and the spike counter SHALL restart at 0.
REQ-018 rate_valid SHALL rise in the cycle after the last window cycle; the first result appears 2^WINDOW_LOG2+1 cycles after en is sampled high.
REQ-019 While rate_valid is high and rate_ready is low, rate SHALL stay stable unless a new window completes.
REQ-020 rate_valid SHALL fall in the cycle after rate_valid and rate_ready are sampled high together, unless a new result is loaded in that same cycle.
REQ-021 If a window completes while rate_valid is high and rate_ready is low, rate SHALL be overwritten with the newer count, rate_valid SHALL stay high, and overrun SHALL be set.
REQ-022 If acceptance and window completion coincide, the new value SHALL load, rate_valid SHALL stay high, and overrun SHALL be unchanged.
REQ-023 overrun SHALL clear only on reset or in IDLE.
REQ-024 When en drops mid-window, the partial count SHALL be discarded, and no result SHALL be produced.

Reset
REQ-025 On rst_n low, asynchronously: state = IDLE; all counters = 0; spike sample register = 0; rate = 0; rate_valid = 0; overrun = 0; isi = 0.

Configuration
REQ-026 With SPIKE_RATE_DECODER_ISI_EN defined, an interval counter SHALL count cycles since the previous spike event, saturating at 255.
- isi SHALL load the interval on each spike event after the first since entering COUNT.
- The interval counter SHALL then restart at 1.
- The count SHALL be the difference of the event cycle indices.
REQ-027 Without SPIKE_RATE_DECODER_ISI_EN, isi SHALL be tied to 0, and no interval logic SHALL be synthesised; the port list SHALL be identical in both builds.

Structure
REQ-028 A shared package lif_pkg SHALL hold the state enum (IDLE, COUNT), the ISI width constant (8), and the default WINDOW_LOG2/OUT_W constants.
REQ-029 The window counter with its last-cycle strobe SHALL be one sub-module, lif_win_counter (parameter WINDOW_LOG2; ports clk, rst_n, run, last).

Verification (bench: WINDOW_LOG2=4, OUT_W=8 unless stated)
REQ-030 en=1, a one-cycle spike every 4 cycles, rate_ready=1 -> rate=4 with rate_valid high for one cycle every 16 cycles; first rate_valid 17 cycles after en.
REQ-031 spike_in held high for 16 cycles, starting mid-window -> exactly one event counted, rate=1 in that window.
REQ-032 WINDOW_LOG2=10, spike_in toggles every cycle -> 512 events, rate=255 (saturated).
REQ-033 rate_ready=0 across two window completions with counts 3 then 5 -> rate=5, rate_valid=1, overrun=1; then en=0 -> overrun=0, rate_valid=0.
REQ-034 Reset asserted and en dropped, each separately mid-window after 2 events -> outputs return to REQ-025 / REQ-014 values, and the next full window reports only its own events.
REQ-035 With ISI_EN, events at cycle 3, 10, and 310 after entering COUNT -> isi=0 after the first event, isi=7 after the second, and isi=255 after the third; without ISI_EN, isi=0 throughout.

Source files
------------

// File: rtl/lif_pkg.sv
// lif_pkg: shared types and constants for the LIF spike-rate decoder.
package lif_pkg;

  // Decoder control states
  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } dec_state_e;

  // Width of the inter-spike interval output
  localparam int ISI_W = 8;

  // Default decoder geometry
  localparam int DEF_WINDOW_LOG2 = 8;
  localparam int DEF_OUT_W       = 8;

  // Saturating increment for the inter-spike interval counter
  function automatic logic [ISI_W-1:0] isi_sat_inc(input logic [ISI_W-1:0] v);
    return (v == '1) ? v : v + ISI_W'(1);
  endfunction

endpackage

// File: rtl/spike_rate_decoder_if.sv
// spike_rate_decoder_if: control inputs and rate result handshake of the decoder.
// master = decoder side, slave = spike source / rate consumer side.
interface spike_rate_decoder_if #(
  parameter int OUT_W = lif_pkg::DEF_OUT_W
);
  logic                       en;
  logic                       spike_in;
  logic                       rate_ready;
  logic [OUT_W-1:0]           rate;
  logic                       rate_valid;
  logic                       overrun;
  logic [lif_pkg::ISI_W-1:0]  isi;

  modport master (
    input  en, spike_in, rate_ready,
    output rate, rate_valid, overrun, isi
  );

  modport slave (
    output en, spike_in, rate_ready,
    input  rate, rate_valid, overrun, isi
  );
endinterface

// File: rtl/lif_win_counter.sv
// lif_win_counter: free-running decode window counter with a last-cycle strobe.
// Held at 0 while run is low; wraps from 2^WINDOW_LOG2-1 to 0 so windows abut.
module lif_win_counter #(
  parameter int WINDOW_LOG2 = lif_pkg::DEF_WINDOW_LOG2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic last
);

  logic [WINDOW_LOG2-1:0] cnt_q;
  logic [WINDOW_LOG2-1:0] cnt_d;

  // Next count: advance while running, otherwise park at the window start
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cnt_d = '0;
    if (run) begin
      cnt_d = cnt_q + WINDOW_LOG2'(1);
    end
  end

  // Window count register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state uses non-blocking assignment so all registers update together at the edge.
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = run && (cnt_q == '1);

endmodule

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: counts rising-edge spike events over back-to-back windows of
// 2^WINDOW_LOG2 cycles and presents each closing count on a valid/ready output.
// Optional inter-spike interval measurement: define SPIKE_RATE_DECODER_ISI_EN.
module spike_rate_decoder
  import lif_pkg::*;
#(
  parameter int WINDOW_LOG2 = DEF_WINDOW_LOG2,
  parameter int OUT_W       = DEF_OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             spike_in,
  input  logic             rate_ready,
  output logic [OUT_W-1:0] rate,
  output logic             rate_valid,
  output logic             overrun,
  output logic [ISI_W-1:0] isi
);

  dec_state_e       state_q;
  logic             spike_q;
  logic [OUT_W-1:0] spike_cnt_q;
  logic [OUT_W-1:0] spike_cnt_d;
  logic [OUT_W-1:0] rate_q;
  logic             rate_valid_q;
  logic             overrun_q;

  logic             active;
  logic             spike_evt;
  logic             win_last;

  // Counting happens only while in COUNT and still enabled; the cycle en drops is discarded.
  assign active    = (state_q == COUNT) && en;
  // A held-high spike produces a single event on its rising edge.
  assign spike_evt = spike_in && !spike_q;

  lif_win_counter #(
    .WINDOW_LOG2(WINDOW_LOG2)
  ) u_win (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (active),
    .last  (win_last)
  );

  // Saturating spike count including this cycle's event
  always_comb begin
    spike_cnt_d = spike_cnt_q;
    if (spike_evt && (spike_cnt_q != '1)) begin
      spike_cnt_d = spike_cnt_q + OUT_W'(1);
    end
  end

  // Control FSM with registered rate, valid and overrun outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      spike_q      <= 1'b0;
      spike_cnt_q  <= '0;
      rate_q       <= '0;
      rate_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      spike_q <= spike_in;
      case (state_q)
        IDLE: begin
          spike_cnt_q  <= '0;
          rate_valid_q <= 1'b0;
          overrun_q    <= 1'b0;
          if (en) begin
            state_q <= COUNT;
          end
        end
        COUNT: begin
          if (!en) begin
            // Partial window is dropped and any pending result is withdrawn.
            state_q      <= IDLE;
            spike_cnt_q  <= '0;
            rate_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
          end else if (win_last) begin
            // A new result always wins over acceptance; overwriting an unread one is flagged.
            rate_q       <= spike_cnt_d;
            spike_cnt_q  <= '0;
            rate_valid_q <= 1'b1;
            if (rate_valid_q && !rate_ready) begin
              overrun_q <= 1'b1;
            end
          end else begin
            spike_cnt_q <= spike_cnt_d;
            if (rate_valid_q && rate_ready) begin
              rate_valid_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rate       = rate_q;
  assign rate_valid = rate_valid_q;
  assign overrun    = overrun_q;

`ifdef SPIKE_RATE_DECODER_ISI_EN
  logic [ISI_W-1:0] ivl_q;
  logic [ISI_W-1:0] isi_q;
  logic             seen_q;

  // Interval counter: restarts at 1 after each event so it equals the event index difference
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ivl_q  <= '0;
      isi_q  <= '0;
      seen_q <= 1'b0;
    end else if (!active) begin
      ivl_q  <= '0;
      seen_q <= 1'b0;
    end else if (spike_evt) begin
      if (seen_q) begin
        isi_q <= ivl_q;
      end
      ivl_q  <= ISI_W'(1);
      seen_q <= 1'b1;
    end else if (seen_q) begin
      ivl_q <= isi_sat_inc(ivl_q);
    end
  end

  assign isi = isi_q;
`else
  assign isi = '0;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb_spike_rate_decoder: directed, table-driven checks of the spike rate decoder
// (WINDOW_LOG2=4 main instance, WINDOW_LOG2=10 instance for saturation).
module tb_spike_rate_decoder;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  spike_rate_decoder_if #(.OUT_W(8)) bus   ();
  spike_rate_decoder_if #(.OUT_W(8)) bus_w ();

  spike_rate_decoder #(.WINDOW_LOG2(4), .OUT_W(8)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (bus.en),
    .spike_in   (bus.spike_in),
    .rate_ready (bus.rate_ready),
    .rate       (bus.rate),
    .rate_valid (bus.rate_valid),
    .overrun    (bus.overrun),
    .isi        (bus.isi)
  );

  spike_rate_decoder #(.WINDOW_LOG2(10), .OUT_W(8)) u_dut_w (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (bus_w.en),
    .spike_in   (bus_w.spike_in),
    .rate_ready (bus_w.rate_ready),
    .rate       (bus_w.rate),
    .rate_valid (bus_w.rate_valid),
    .overrun    (bus_w.overrun),
    .isi        (bus_w.isi)
  );

`ifdef SPIKE_RATE_DECODER_ISI_EN
  localparam logic [31:0] ISI_EXP_2 = 32'd7;
  localparam logic [31:0] ISI_EXP_3 = 32'd255;
`else
  localparam logic [31:0] ISI_EXP_2 = 32'd0;
  localparam logic [31:0] ISI_EXP_3 = 32'd0;
`endif

  typedef struct {
    logic [15:0] mask;      // bit c = spike_in during window cycle c
    logic [7:0]  exp_rate;
  } win_vec_t;

  win_vec_t vecs [11];

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    bus.en         = 1'b0;
    bus.spike_in   = 1'b0;
    bus.rate_ready = 1'b1;
    bus_w.en         = 1'b0;
    bus_w.spike_in   = 1'b0;
    bus_w.rate_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One cycle with en high in IDLE: the decoder enters COUNT at window cycle 0.
  task automatic enable();
    bus.en       = 1'b1;
    bus.spike_in = 1'b0;
    tick();
  endtask

  task automatic run_window(input logic [15:0] mask, input logic rdy, input logic rdy_last);
    for (int c = 0; c < 16; c++) begin
      bus.spike_in   = mask[c[3:0]];
      bus.rate_ready = (c == 15) ? rdy_last : rdy;
      tick();
    end
    bus.spike_in = 1'b0;
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic early;

    vecs[0]  = '{mask: 16'h1111, exp_rate: 8'd4};
    vecs[1]  = '{mask: 16'h0000, exp_rate: 8'd0};
    vecs[2]  = '{mask: 16'h5555, exp_rate: 8'd8};
    vecs[3]  = '{mask: 16'hFF00, exp_rate: 8'd1};
    vecs[4]  = '{mask: 16'h00FF, exp_rate: 8'd0};
    vecs[5]  = '{mask: 16'h8001, exp_rate: 8'd2};
    vecs[6]  = '{mask: 16'h0003, exp_rate: 8'd0};
    vecs[7]  = '{mask: 16'hAAAA, exp_rate: 8'd8};
    vecs[8]  = '{mask: 16'hFFFF, exp_rate: 8'd0};
    vecs[9]  = '{mask: 16'h0F0F, exp_rate: 8'd1};
    vecs[10] = '{mask: 16'h1111, exp_rate: 8'd4};

    // Reset state of both instances
    do_reset();
    check("rst_rate",       32'(bus.rate),         32'd0);
    check("rst_valid",      32'(bus.rate_valid),   32'd0);
    check("rst_overrun",    32'(bus.overrun),      32'd0);
    check("rst_isi",        32'(bus.isi),          32'd0);
    check("rst_w_rate",     32'(bus_w.rate),       32'd0);
    check("rst_w_valid",    32'(bus_w.rate_valid), 32'd0);

    // Back-to-back windows, consumer always ready
    bus.rate_ready = 1'b1;
    enable();
    check("enter_count_valid", 32'(bus.rate_valid), 32'd0);
    early = 1'b0;
    for (int w = 0; w < 11; w++) begin
      for (int c = 0; c < 16; c++) begin
        bus.spike_in = vecs[w].mask[c[3:0]];
        tick();
        if (w == 0 && c < 15 && bus.rate_valid) early = 1'b1;
        if (w > 0 && c == 0)
          check($sformatf("vec%0d_accept_drop", w - 1), 32'(bus.rate_valid), 32'd0);
        if (c == 15) begin
          check($sformatf("vec%0d_valid", w), 32'(bus.rate_valid), 32'd1);
          check($sformatf("vec%0d_rate", w),  32'(bus.rate),       32'(vecs[w].exp_rate));
        end
      end
    end
    check("first_result_not_early", 32'(early), 32'd0);
    check("ready_no_overrun", 32'(bus.overrun), 32'd0);

    // Two completions without acceptance: overwrite and sticky overrun, then en low clears
    do_reset();
    enable();
    run_window(16'h002A, 1'b0, 1'b0);
    check("hold_a_rate",    32'(bus.rate),       32'd3);
    check("hold_a_valid",   32'(bus.rate_valid), 32'd1);
    check("hold_a_overrun", 32'(bus.overrun),    32'd0);
    run_window(16'h02AA, 1'b0, 1'b0);
    check("ovr_rate",    32'(bus.rate),       32'd5);
    check("ovr_valid",   32'(bus.rate_valid), 32'd1);
    check("ovr_overrun", 32'(bus.overrun),    32'd1);
    bus.rate_ready = 1'b0;
    repeat (4) tick();
    check("stall_rate_stable",  32'(bus.rate),       32'd5);
    check("stall_valid_stable", 32'(bus.rate_valid), 32'd1);
    bus.en = 1'b0;
    tick();
    check("idle_overrun_clr", 32'(bus.overrun),    32'd0);
    check("idle_valid_clr",   32'(bus.rate_valid), 32'd0);
    check("idle_rate_kept",   32'(bus.rate),       32'd5);

    // Acceptance coinciding with a completion: new value loads, valid stays, no overrun
    enable();
    run_window(16'h0111, 1'b0, 1'b0);
    check("coin_pre_rate", 32'(bus.rate), 32'd3);
    run_window(16'h0001, 1'b0, 1'b1);
    check("coin_rate",    32'(bus.rate),       32'd1);
    check("coin_valid",   32'(bus.rate_valid), 32'd1);
    check("coin_overrun", 32'(bus.overrun),    32'd0);
    bus.rate_ready = 1'b1;
    tick();
    check("coin_accept_drop", 32'(bus.rate_valid), 32'd0);

    // Asynchronous reset mid-window after two events
    do_reset();
    enable();
    run_window(16'h1111, 1'b0, 1'b0);
    for (int c = 0; c < 8; c++) begin
      bus.spike_in = (c == 1 || c == 3);
      tick();
    end
    rst_n = 1'b0;
    #2;
    check("async_rst_rate",    32'(bus.rate),       32'd0);
    check("async_rst_valid",   32'(bus.rate_valid), 32'd0);
    check("async_rst_overrun", 32'(bus.overrun),    32'd0);
    bus.spike_in = 1'b0;
    tick();
    rst_n = 1'b1;
    enable();
    run_window(16'h0111, 1'b1, 1'b1);
    check("post_rst_valid", 32'(bus.rate_valid), 32'd1);
    check("post_rst_rate",  32'(bus.rate),       32'd3);

    // en dropped mid-window after two events: partial count discarded
    do_reset();
    enable();
    run_window(16'h1111, 1'b0, 1'b0);
    for (int c = 0; c < 8; c++) begin
      bus.spike_in = (c == 1 || c == 3);
      tick();
    end
    bus.spike_in = 1'b0;
    bus.en       = 1'b0;
    tick();
    check("drop_valid",   32'(bus.rate_valid), 32'd0);
    check("drop_overrun", 32'(bus.overrun),    32'd0);
    for (int c = 0; c < 4; c++) begin
      bus.spike_in = (c % 2 == 0);
      tick();
    end
    bus.spike_in = 1'b0;
    tick();
    check("drop_idle_rate_kept", 32'(bus.rate),       32'd4);
    check("drop_idle_no_result", 32'(bus.rate_valid), 32'd0);
    enable();
    run_window(16'h0007, 1'b1, 1'b1);
    check("post_drop_valid", 32'(bus.rate_valid), 32'd1);
    check("post_drop_rate",  32'(bus.rate),       32'd1);

    // 1024-cycle window with a toggling spike train saturates the count
    do_reset();
    bus_w.en         = 1'b1;
    bus_w.rate_ready = 1'b1;
    bus_w.spike_in   = 1'b0;
    tick();
    early = 1'b0;
    for (int c = 0; c < 1024; c++) begin
      bus_w.spike_in = (c % 2 == 0);
      tick();
      if (c < 1023 && bus_w.rate_valid) early = 1'b1;
    end
    bus_w.spike_in = 1'b0;
    check("sat_valid",          32'(bus_w.rate_valid), 32'd1);
    check("sat_rate",           32'(bus_w.rate),       32'd255);
    check("sat_window_not_short", 32'(early),          32'd0);

    // Inter-spike interval: events at cycles 3, 10 and 310 after entering COUNT
    do_reset();
    enable();
    bus.rate_ready = 1'b1;
    for (int c = 0; c <= 320; c++) begin
      bus.spike_in = (c == 3 || c == 10 || c == 310);
      tick();
      if (c == 3)   check("isi_first_event",  32'(bus.isi), 32'd0);
      if (c == 9)   check("isi_before_second", 32'(bus.isi), 32'd0);
      if (c == 10)  check("isi_second_event", 32'(bus.isi), ISI_EXP_2);
      if (c == 200) check("isi_held",         32'(bus.isi), ISI_EXP_2);
      if (c == 310) check("isi_third_event",  32'(bus.isi), ISI_EXP_3);
    end
    bus.spike_in = 1'b0;
    check("isi_final", 32'(bus.isi), ISI_EXP_3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
